// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed load/store unit in front of a word-wide data memory.
// Ports: REQ_* from execute (valid/ready), RSP_* to writeback, DMEM_* to the memory.
module dmem_lsu #(
  parameter int          ADDR_DEPTH = 14,
  parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
  parameter int          DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_STORE,
  input  logic [2:0]            REQ_FUNCT3,
  input  logic [31:0]           REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RDATA,
  output logic                  RSP_FAULT,
  output logic                  DMEM_RDEN,
  output logic                  DMEM_WEN,
  output logic [ADDR_DEPTH-1:0] DMEM_ADDR,
  output logic [1:0]            DMEM_BYTE_SEL,
  output logic                  DMEM_SIGN,
  output logic [DATA_WIDTH-1:0] DMEM_DATA_IN,
  input  logic [DATA_WIDTH-1:0] DMEM_DATA_OUT
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic                  st_q;
  logic [2:0]            f3_q;
  logic [ADDR_DEPTH+1:0] off_q;
  logic [15:0]           wdata_q;
  logic [31:0]           rdata_q;
  logic [31:0]           din_q;
  logic                  fault_q;

  logic        accept;
  logic [31:0] off_in;
  logic        f3_bad;
  logic        misal;
  logic        out_rng;
  logic        fault_in;
  logic        is_sw;

  assign REQ_READY = (state_q == S_IDLE) & ~RST;
  assign accept    = REQ_VALID & REQ_READY;
  assign off_in    = REQ_ADDR - DATA_BASE;

  assign f3_bad  = (REQ_FUNCT3 == 3'b011)
                 | (REQ_FUNCT3[2:1] == 2'b11)
                 | (REQ_STORE & REQ_FUNCT3[2]);
  assign misal   = ((REQ_FUNCT3[1:0] == 2'b01) & off_in[0])
                 | ((REQ_FUNCT3[1:0] == 2'b10) & (off_in[1:0] != 2'b00));
  assign out_rng = (REQ_ADDR < DATA_BASE)
                 | ((off_in >> (ADDR_DEPTH + 2)) != 32'd0);
  assign fault_in = f3_bad | misal | out_rng;
  assign is_sw    = REQ_STORE & (REQ_FUNCT3 == 3'b010);

  // Strobes come straight from the state register.
  assign DMEM_RDEN     = (state_q == S_READ);
  assign DMEM_WEN      = (state_q == S_WRITE);
  assign RSP_VALID     = (state_q == S_RESP);
  assign DMEM_ADDR     = off_q[ADDR_DEPTH+1:2];
  assign DMEM_BYTE_SEL = 2'b10;
  assign DMEM_SIGN     = 1'b0;
  assign DMEM_DATA_IN  = din_q;
  assign RSP_RDATA     = rdata_q;
  assign RSP_FAULT     = fault_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (fault_in)   state_d = S_RESP;
          else if (is_sw) state_d = S_WRITE;
          else            state_d = S_READ;
        end
      end
      S_READ:    state_d = S_CAPTURE;
      S_CAPTURE: state_d = st_q ? S_WRITE : S_RESP;
      S_WRITE:   state_d = S_RESP;
      S_RESP:    if (RSP_READY) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  logic [4:0]  sh;
  logic [31:0] sh_word;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_val;
  logic [31:0] st_val;

  assign sh      = {off_q[1:0], 3'b000};
  assign sh_word = DMEM_DATA_OUT >> sh;
  assign ld_b    = sh_word[7:0];
  assign ld_h    = off_q[1] ? DMEM_DATA_OUT[31:16]
                            : DMEM_DATA_OUT[15:0];

  always_comb begin
    ld_val = DMEM_DATA_OUT;
    case (f3_q)
      3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
      3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
      3'b100:  ld_val = {24'd0, ld_b};
      3'b101:  ld_val = {16'd0, ld_h};
      default: ld_val = DMEM_DATA_OUT;
    endcase
  end

  always_comb begin
    st_val = DMEM_DATA_OUT;
    if (f3_q[1:0] == 2'b00) begin
      st_val = (DMEM_DATA_OUT & ~(32'h0000_00FF << sh))
             | ({24'd0, wdata_q[7:0]} << sh);
    end else if (off_q[1]) begin
      st_val = {wdata_q, DMEM_DATA_OUT[15:0]};
    end else begin
      st_val = {DMEM_DATA_OUT[31:16], wdata_q};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      st_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= '0;
      wdata_q <= 16'd0;
      rdata_q <= 32'd0;
      din_q   <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        st_q    <= REQ_STORE;
        f3_q    <= REQ_FUNCT3;
        off_q   <= off_in[ADDR_DEPTH+1:0];
        wdata_q <= REQ_WDATA[15:0];
        rdata_q <= 32'd0;
        fault_q <= fault_in;
        if (is_sw && !fault_in) din_q <= REQ_WDATA;
      end
      if (state_q == S_CAPTURE) begin
        if (st_q) din_q <= st_val;
        else      rdata_q <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: random and directed checks of dmem_lsu against a byte-level
// memory model, with a registered-read memory attached to the DMEM port.
module tb_dmem_lsu;

  localparam int          DEPTH = 14;
  localparam int          NW    = 1 << DEPTH;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic        REQ_STORE = 1'b0;
  logic [2:0]  REQ_FUNCT3 = 3'd0;
  logic [31:0] REQ_ADDR = 32'd0;
  logic [31:0] REQ_WDATA = 32'd0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b1;
  logic [31:0] RSP_RDATA;
  logic        RSP_FAULT;
  logic        DMEM_RDEN;
  logic        DMEM_WEN;
  logic [13:0] DMEM_ADDR;
  logic [1:0]  DMEM_BYTE_SEL;
  logic        DMEM_SIGN;
  logic [31:0] DMEM_DATA_IN;
  logic [31:0] DMEM_DATA_OUT;

  dmem_lsu #(
    .ADDR_DEPTH(DEPTH),
    .DATA_BASE (BASE),
    .DATA_WIDTH(32)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .REQ_VALID    (REQ_VALID),
    .REQ_READY    (REQ_READY),
    .REQ_STORE    (REQ_STORE),
    .REQ_FUNCT3   (REQ_FUNCT3),
    .REQ_ADDR     (REQ_ADDR),
    .REQ_WDATA    (REQ_WDATA),
    .RSP_VALID    (RSP_VALID),
    .RSP_READY    (RSP_READY),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_FAULT    (RSP_FAULT),
    .DMEM_RDEN    (DMEM_RDEN),
    .DMEM_WEN     (DMEM_WEN),
    .DMEM_ADDR    (DMEM_ADDR),
    .DMEM_BYTE_SEL(DMEM_BYTE_SEL),
    .DMEM_SIGN    (DMEM_SIGN),
    .DMEM_DATA_IN (DMEM_DATA_IN),
    .DMEM_DATA_OUT(DMEM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  bit [31:0]   mem     [NW];
  bit [31:0]   ref_mem [NW];
  logic [31:0] rd_q = 32'd0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [13:0] last_wa = 14'd0;
  logic [31:0] last_wd = 32'd0;

  assign DMEM_DATA_OUT = rd_q;

  always @(posedge CLK) begin
    if (DMEM_WEN) begin
      mem[DMEM_ADDR] <= DMEM_DATA_IN;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= DMEM_ADDR;
      last_wd <= DMEM_DATA_IN;
    end
    if (DMEM_RDEN) begin
      rd_q   <= mem[DMEM_ADDR];
      rd_cnt <= rd_cnt + 1;
    end
    if (DMEM_RDEN && DMEM_WEN) both_cnt <= both_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] get_b(input logic [31:0] off);
    logic [31:0] w;
    w = ref_mem[off >> 2] >> (8 * off[1:0]);
    return w[7:0];
  endfunction

  function automatic void put_b(input logic [31:0] off, input logic [7:0] b);
    int sh;
    sh = 8 * int'(off[1:0]);
    ref_mem[off >> 2] = (ref_mem[off >> 2] & ~(32'hFF << sh))
                      | ({24'd0, b} << sh);
  endfunction

  // Reference: access as a sequence of bytes in little-endian order.
  function automatic void model(
    input logic st, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] wd,
    output logic flt, output logic [31:0] rd,
    output int lat, output int nrd, output int nwr);
    bit          legal;
    int          size;
    logic [31:0] off;
    logic [63:0] v;
    logic [31:0] wsh;
    legal = st ? (f3 inside {3'd0, 3'd1, 3'd2})
               : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    off = a - BASE;
    flt = !legal
       || (longint'(a) < longint'(BASE))
       || ((off & 32'(size - 1)) != 0)
       || (longint'(off) >= 4 * longint'(NW));
    rd = 32'd0; lat = 1; nrd = 0; nwr = 0;
    if (flt) return;
    if (!st) begin
      v = 64'd0;
      for (int i = 0; i < size; i++)
        v = v | ({56'd0, get_b(off + 32'(i))} << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1])
        v = v | ~((64'd1 << (8 * size)) - 64'd1);
      rd = v[31:0]; lat = 3; nrd = 1;
    end else begin
      for (int i = 0; i < size; i++) begin
        wsh = wd >> (8 * i);
        put_b(off + 32'(i), wsh[7:0]);
      end
      nwr = 1;
      nrd = (size == 4) ? 0 : 1;
      lat = (size == 4) ? 2 : 4;
    end
  endfunction

  task automatic send(input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int r0, output int w0);
    int c;
    @(negedge CLK);
    REQ_VALID = 1'b1; REQ_STORE = st; REQ_FUNCT3 = f3;
    REQ_ADDR = a; REQ_WDATA = wd;
    c = 0;
    while (!REQ_READY && c < 20) begin @(negedge CLK); c++; end
    if (!REQ_READY) chk("req_ready_timeout", 32'(REQ_READY), 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge CLK);
    #1 REQ_VALID = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    @(negedge CLK);
    while (!RSP_VALID && lat < 20) begin @(negedge CLK); lat++; end
  endtask

  task automatic run(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    logic        ef;
    logic [31:0] er;
    int          el, enr, enw, r0, w0, lat;
    logic        flt;
    logic [13:0] wi;
    model(st, f3, a, wd, ef, er, el, enr, enw);
    send(st, f3, a, wd, r0, w0);
    wait_rsp(lat);
    rd = RSP_RDATA; flt = RSP_FAULT;
    chk({tag, "_lat"}, 32'(lat), 32'(el));
    chk({tag, "_fault"}, 32'(flt), 32'(ef));
    chk({tag, "_rdata"}, rd, er);
    @(negedge CLK);
    chk({tag, "_nrd"}, 32'(rd_cnt - r0), 32'(enr));
    chk({tag, "_nwr"}, 32'(wr_cnt - w0), 32'(enw));
    if (!ef && st) begin
      wi = a[15:2];
      chk({tag, "_mem"}, mem[wi], ref_mem[wi]);
    end
  endtask

  logic [31:0] rd;
  int          r0, w0, lat, bad, r, mism;
  logic        st;
  logic [2:0]  f3;
  logic [31:0] a;

  initial begin
    repeat (2) @(negedge CLK);
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_strobes", {30'd0, DMEM_RDEN, DMEM_WEN}, 32'd0);
    chk("rst_addr", 32'(DMEM_ADDR), 32'd0);
    chk("tie_offs", {29'd0, DMEM_BYTE_SEL, DMEM_SIGN}, 32'd4);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_ready", 32'(REQ_READY), 32'd1);

    run("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    chk("sw10_waddr", 32'(last_wa), 32'd4);
    chk("sw10_wdata", last_wd, 32'hDEADBEEF);
    run("lb13", 1'b0, 3'b000, 32'h13, 32'd0, rd);
    chk("lb13_k", rd, 32'hFFFFFFDE);
    run("lbu13", 1'b0, 3'b100, 32'h13, 32'd0, rd);
    chk("lbu13_k", rd, 32'h000000DE);
    run("lh10", 1'b0, 3'b001, 32'h10, 32'd0, rd);
    chk("lh10_k", rd, 32'hFFFFBEEF);
    run("lhu12", 1'b0, 3'b101, 32'h12, 32'd0, rd);
    chk("lhu12_k", rd, 32'h0000DEAD);
    run("sb11", 1'b1, 3'b000, 32'h11, 32'h12, rd);
    chk("sb11_k", mem[4], 32'hDEAD12EF);
    run("sh12", 1'b1, 3'b001, 32'h12, 32'h5678, rd);
    chk("sh12_k", mem[4], 32'h567812EF);
    run("lw_mis", 1'b0, 3'b010, 32'h12, 32'd0, rd);
    chk("lw_mis_k", 32'(RSP_FAULT), 32'd1);
    run("sh_mis", 1'b1, 3'b001, 32'h11, 32'hFFFF, rd);
    run("f3_011", 1'b0, 3'b011, 32'h10, 32'd0, rd);
    run("sbu_ill", 1'b1, 3'b100, 32'h10, 32'd0, rd);
    run("oor", 1'b0, 3'b010, 32'h10000, 32'd0, rd);
    chk("oor_k", 32'(RSP_FAULT), 32'd1);
    run("last_sw", 1'b1, 3'b010, 32'hFFFC, 32'hCAFEF00D, rd);
    run("last_lw", 1'b0, 3'b010, 32'hFFFC, 32'd0, rd);
    chk("last_lw_k", rd, 32'hCAFEF00D);
    run("last_lbu", 1'b0, 3'b100, 32'hFFFF, 32'd0, rd);
    run("past_lb", 1'b0, 3'b000, 32'h10000, 32'd0, rd);

    // Response backpressure with a competing request.
    RSP_READY = 1'b0;
    send(1'b0, 3'b010, 32'h10, 32'd0, r0, w0);
    wait_rsp(lat);
    chk("hold_lat", 32'(lat), 32'd3);
    rd = RSP_RDATA;
    chk("hold_rdata", rd, 32'h567812EF);
    REQ_VALID = 1'b1; REQ_STORE = 1'b1; REQ_FUNCT3 = 3'b010;
    REQ_ADDR = 32'h20; REQ_WDATA = 32'h1;
    bad = 0;
    repeat (5) begin
      @(negedge CLK);
      if (!RSP_VALID || RSP_RDATA !== rd || REQ_READY) bad++;
    end
    chk("hold_stable", 32'(bad), 32'd0);
    REQ_VALID = 1'b0; RSP_READY = 1'b1;
    @(negedge CLK);
    chk("hold_rel_ready", 32'(REQ_READY), 32'd1);
    chk("hold_rel_valid", 32'(RSP_VALID), 32'd0);
    chk("hold_nwr", 32'(wr_cnt - w0), 32'd0);
    run("after_hold", 1'b0, 3'b010, 32'h20, 32'd0, rd);

    // Reset in the capture cycle of a byte store.
    send(1'b1, 3'b000, 32'h11, 32'hAA, r0, w0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_mid_nrd", 32'(rd_cnt - r0), 32'd1);
    RST = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(REQ_READY), 32'd0);
    chk("rst_mid_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_mid_rsp", {RSP_RDATA[30:0], RSP_FAULT}, 32'd0);
    chk("rst_mid_strobes", {30'd0, DMEM_RDEN, DMEM_WEN}, 32'd0);
    chk("rst_mid_addr", 32'(DMEM_ADDR), 32'd0);
    chk("rst_mid_din", DMEM_DATA_IN, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_mid_nwr", 32'(wr_cnt - w0), 32'd0);
    chk("rst_mid_mem", mem[4], 32'h567812EF);
    chk("rst_mid_idle", 32'(REQ_READY), 32'd1);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if (r < 6)      a = 32'($urandom_range(0, 63));
      else if (r < 8) a = 32'h0000_FFC0 + 32'($urandom_range(0, 79));
      else            a = $urandom;
      run("rnd", st, f3, a, $urandom, rd);
    end

    chk("rd_wr_overlap", 32'(both_cnt), 32'd0);
    mism = 0;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_all", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit directly upstream of the 64 kB word-addressed data memory; the memory exposes one full 32-bit word per address.
- Accepts one byte-addressed load/store per valid/ready handshake from the execute stage and converts byte addresses to word addresses.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write for sub-word stores.
- Returns one response per request to the writeback stage, with a fault flag for misaligned, out-of-range or illegal requests.

Parameters:
- ADDR_DEPTH, 14, word-address width of the data memory (2^14 words).
- DATA_BASE, 32'h0000_0000, byte address of memory word 0.
- DATA_WIDTH, 32, data width (fixed at 32).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  unit idle and able to accept a request.
- REQ_STORE  in  1  1 = store, 0 = load.
- REQ_FUNCT3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- REQ_ADDR  in  32  byte address.
- REQ_WDATA  in  32  store data; only the low bits are used for B/H.
- RSP_VALID  out  1  response valid.
- RSP_READY  in  1  consumer accepts the response.
- RSP_RDATA  out  32  extended load data; 0 for stores and faults.
- RSP_FAULT  out  1  request was rejected; memory is untouched.
- DMEM_RDEN  out  1  memory read enable.
- DMEM_WEN  out  1  memory write enable.
- DMEM_ADDR  out  ADDR_DEPTH  word address.
- DMEM_BYTE_SEL  out  2  tied to 2'b10 (word).
- DMEM_SIGN  out  1  tied to 0.
- DMEM_DATA_IN  out  32  write word.
- DMEM_DATA_OUT  in  32  read word; registered, valid the cycle after DMEM_RDEN.

Behaviour:
- Reset values (async): state IDLE; RSP_VALID=0, RSP_RDATA=0, RSP_FAULT=0; DMEM_RDEN=0, DMEM_WEN=0; DMEM_ADDR=0, DMEM_DATA_IN=0; all latched request registers cleared.
- REQ_READY = (state==IDLE) & ~RST.
- Reset mid-operation aborts immediately; no write is issued for a pending RMW.
- Accept: in IDLE, on REQ_VALID & REQ_READY, latch STORE, FUNCT3, offset = REQ_ADDR - DATA_BASE, and WDATA.
- Fault check on the accept cycle:
  - Illegal FUNCT3: 011, 110, 111, or any 1xx on a store.
  - Misalignment: H/HU with offset[0]=1; W with offset[1:0]≠0.
  - Range: REQ_ADDR < DATA_BASE, or offset[31:2] ≥ 2^ADDR_DEPTH.
  - On any fault → RESP with FAULT=1, RDATA=0; no DMEM access.
- DMEM_ADDR = offset[ADDR_DEPTH+1:2].
- DMEM_RDEN and DMEM_WEN are decoded from the state register only (glitch-free); they are never high together.
- State machine:
  - IDLE: on accept → RESP (fault), WRITE (SW), READ (load, SB, SH).
  - READ: DMEM_RDEN=1 for one cycle → CAPTURE.
  - CAPTURE: DMEM_DATA_OUT is valid.
    - Load: RSP_RDATA <= lane select by offset[1:0], then sign-extend (B/H) or zero-extend (BU/HU); W passes through → RESP.
    - Sub-word store: DMEM_DATA_IN <= read word with the selected byte (lane offset[1:0]) or halfword (lane offset[1]) replaced by WDATA → WRITE.
  - WRITE: DMEM_WEN=1 for one cycle; for SW, DMEM_DATA_IN = WDATA → RESP.
  - RESP: RSP_VALID=1; RDATA/FAULT held stable until RSP_READY; on RSP_READY → IDLE, RSP_VALID=0 next cycle.
- Latency (accept edge to RSP_VALID rising), RSP_READY held high throughout:
  - Fault: 1 cycle.
  - SW: 2 cycles.
  - Load: 3 cycles.
  - SB/SH: 4 cycles.
- No overlap: REQ_READY is 0 from the cycle after accept until the cycle after the response handshake.
- Single-cycle RSP_READY pulse is sufficient; RSP_READY while RSP_VALID=0 is ignored.
- Boundary: the last word (offset = 4·(2^ADDR_DEPTH)−4) is legal; the next byte address faults.
- Loads never write memory; faulted stores never write memory.

Test Plan:
- Reset, then SW addr 0x10 data 0xDEADBEEF → DMEM_WEN one cycle with DMEM_ADDR=4, DATA_IN=0xDEADBEEF; RSP_VALID 2 cycles after accept, FAULT=0.
- After the above, LB addr 0x13 → RDATA=0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x10 → 0xFFFFBEEF; LHU 0x12 → 0x0000DEAD; each RSP_VALID 3 cycles after accept.
- SB addr 0x11 data 0x12 → read, then write 0xDEAD12EF to word 4 (RSP 4 cycles after accept); then SH addr 0x12 data 0x5678 → word becomes 0x567812EF.
- LW addr 0x12, SH addr 0x11, FUNCT3 011, and addr 0x10000 (default params) → FAULT=1, RDATA=0 after 1 cycle, DMEM_RDEN and DMEM_WEN never asserted.
- Hold RSP_READY=0 for 5 cycles after a load → RSP_VALID/RDATA stable, REQ_READY=0, a second REQ_VALID is not accepted; release → IDLE and accept on the next cycle.
- Assert RST in the CAPTURE state of an SB → state IDLE immediately, DMEM_WEN never pulses, memory word unchanged, all outputs at their reset values.
